// File: rtl/lsu_dword_access.sv
// Doubleword LD/SD execution stage: forms base+imm, runs one request/ready
// memory transaction and reports completion status to the control FSM.
module lsu_dword_access #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] imm64,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] load_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_inc;
    logic [ADDR_W-1:0] ea_now;
    logic [1:0]        err_nxt;

    assign ea_now  = ADDR_W'(base) + ADDR_W'(imm64);
    assign cnt_inc = cnt + 1'b1;

    // Handshake outputs decode straight from state so an async reset drops them at once.
    assign mem_req = (state == ACCESS);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        case (state)
            IDLE: if (start) begin
                if (is_load == is_store) begin
                    state_nxt = DONE;
                    err_nxt   = 2'd3;
                end else if (ea_now[2:0] != 3'd0) begin
                    state_nxt = DONE;
                    err_nxt   = 2'd1;
                end else begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // mem_ready wins over a timeout landing on the same cycle
                if (mem_ready) begin
                    state_nxt = DONE;
                    err_nxt   = 2'd0;
                end else if (TIMEOUT != 0 && cnt_inc == TO) begin
                    state_nxt = DONE;
                    err_nxt   = 2'd2;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_code  <= 2'd0;
            load_data <= '0;
            cnt       <= '0;
        end else begin
            err_code <= err_nxt;
            if (state == IDLE && start) begin
                mem_addr  <= ea_now;
                mem_wdata <= store_data;
                mem_we    <= is_store;
                cnt       <= '0;
            end
            if (state == ACCESS) begin
                cnt <= cnt_inc;
                if (mem_ready && !mem_we) load_data <= mem_rdata;
            end
        end
    end
endmodule
